// File: rtl/fetch_execute_sequencer.sv
// Fetch/decode/execute control sequencer: INIT -> T0 -> T1 -> T2 [-> T3] -> T0, with HALT.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_COUNT_EN.
module fetch_execute_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic        Halted,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {INIT, T0, T1, T2, T3, HALT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  w_class;
  logic [3:0]  w_op;
  logic        w_s;
  logic [1:0]  w_dst;
  logic [1:0]  w_src1;
  logic [1:0]  w_src2;
  logic        w_taken;
  logic        w_unused;

  assign w_class  = IROut[15:14];
  assign w_op     = IROut[13:10];
  assign w_s      = IROut[9];
  assign w_dst    = IROut[7:6];
  assign w_src1   = IROut[4:3];
  assign w_src2   = IROut[1:0];
  assign w_unused = ^{Flags[1:0], IROut[8], IROut[5], IROut[2]};

  always_comb begin
    case (w_op)
      4'b0000: w_taken = 1'b1;
      4'b0001: w_taken = Flags[3];
      4'b0010: w_taken = ~Flags[3];
      4'b0011: w_taken = Flags[2];
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT: w_next = T0;
      T0:   w_next = T1;
      T1:   w_next = T2;
      T2: begin
        case (w_class)
          2'b00:   w_next = (w_op == 4'b1111) ? HALT : T0;
          2'b01:   w_next = T0;
          2'b10:   w_next = IROut[13] ? T0 : T3;
          default: w_next = HALT;
        endcase
      end
      T3:      w_next = T0;
      HALT:    w_next = HALT;
      default: w_next = INIT;
    endcase
  end

  // Reset gates every output to idle in the same cycle, so the reset edge never writes.
  always_comb begin
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_FunSel   = '0;
    RF_RegSel   = '0;
    RF_ScrSel   = '0;
    ALU_FunSel  = '0;
    ALU_WF      = 1'b0;
    ARF_OutCSel = '0;
    ARF_OutDSel = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = '0;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = '0;
    MuxDSel     = 1'b0;
    DR_E        = 1'b0;
    DR_FunSel   = '0;
    Halted      = 1'b0;
    if (Reset) begin
      case (r_state)
        INIT: begin
          ARF_RegSel = 3'b111;
          ARF_FunSel = 2'b11;
          RF_RegSel  = 4'b1111;
          RF_ScrSel  = 4'b1111;
          RF_FunSel  = 3'b011;
        end
        T0, T1: begin
          ARF_OutDSel = 2'b00;
          Mem_CS      = 1'b0;
          IR_Write    = 1'b1;
          IR_LH       = (r_state == T1);
          ARF_RegSel  = 3'b100;
          ARF_FunSel  = 2'b01;
        end
        T2: begin
          case (w_class)
            2'b01: begin
              RF_OutASel = {1'b0, w_src1};
              RF_OutBSel = {1'b0, w_src2};
              ALU_FunSel = {1'b1, w_op};
              ALU_WF     = w_s;
              RF_FunSel  = 3'b010;
              RF_RegSel  = 4'b1000 >> w_dst;
            end
            2'b00: begin
              if (w_taken) begin
                MuxBSel    = 2'b11;
                ARF_RegSel = 3'b100;
                ARF_FunSel = 2'b10;
              end
            end
            2'b10: begin
              ARF_OutDSel = 2'b01;
              Mem_CS      = 1'b0;
              if (IROut[13]) begin
                RF_OutASel = {1'b0, w_src1};
                ALU_FunSel = 5'b10000;
                Mem_WR     = 1'b1;
              end else begin
                DR_E      = 1'b1;
                DR_FunSel = 2'b01;
              end
            end
            default: ;
          endcase
        end
        T3: begin
          MuxASel   = 2'b10;
          RF_FunSel = 3'b010;
          RF_RegSel = 4'b1000 >> w_dst;
        end
        HALT:    Halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] r_instr_count;
  logic        w_retire;

  assign w_retire = ((r_state == T2) && (w_next == T0)) || (r_state == T3);

  always_ff @(posedge Clock) begin
    if (!Reset)        r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + 16'd1;
  end

  assign InstrCount = r_instr_count;
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_fetch_execute_sequencer.sv
// Bench for fetch_execute_sequencer: directed vector table, hand-written reset/halt sequences,
// and random instructions checked against an instruction-level reference model.
module tb_fetch_execute_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IROut = '0;
  logic [3:0]  Flags = '0;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_CS, Mem_WR;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel;
  logic        MuxDSel, DR_E;
  logic [1:0]  DR_FunSel;
  logic        Halted;
  logic [15:0] InstrCount;

  typedef struct packed {
    logic [2:0] asel, bsel, rffun;
    logic [3:0] rfreg, scr;
    logic [4:0] alufun;
    logic       wf;
    logic [1:0] csel, dsel, arffun;
    logic [2:0] arfreg;
    logic       lh, irw, cs, wr;
    logic [1:0] ma, mb, mc;
    logic       md, dre;
    logic [1:0] drfun;
    logic       halted;
  } out_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  fl;
    logic [2:0]  e_arfreg;
    logic [4:0]  e_alufun;
    logic [3:0]  e_rfreg;
    logic [1:0]  e_mb;
  } vec_t;

  out_t        act;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_count = '0;

  assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
                ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_CS,
                Mem_WR, MuxASel, MuxBSel, MuxCSel, MuxDSel, DR_E, DR_FunSel, Halted};

  fetch_execute_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_CS(Mem_CS),
    .Mem_WR(Mem_WR), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .MuxDSel(MuxDSel), .DR_E(DR_E), .DR_FunSel(DR_FunSel), .Halted(Halted),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t idle_out();
    out_t o = '0;
    o.cs = 1'b1;
    return o;
  endfunction

  function automatic out_t init_out();
    out_t o = idle_out();
    o.arfreg = 3'b111; o.arffun = 2'b11;
    o.rfreg = 4'b1111; o.scr = 4'b1111; o.rffun = 3'b011;
    return o;
  endfunction

  function automatic bit is_halt(input logic [15:0] ir);
    return (ir[15:14] == 2'b11) || (ir[15:14] == 2'b00 && ir[13:10] == 4'b1111);
  endfunction

  function automatic int instr_len(input logic [15:0] ir);
    return (ir[15:14] == 2'b10 && !ir[13]) ? 4 : 3;
  endfunction

  // Expected control word for cycle p of an instruction (0,1 fetch; 2 execute; 3 LD write-back).
  function automatic out_t exp_out(input int p, input logic [15:0] ir, input logic [3:0] fl);
    out_t o = idle_out();
    logic [3:0] op = ir[13:10];
    logic [1:0] dst = ir[7:6];
    bit taken;
    if (p <= 1) begin
      o.cs = 1'b0; o.irw = 1'b1; o.lh = (p == 1); o.arfreg = 3'b100; o.arffun = 2'b01;
    end else if (p == 3) begin
      o.ma = 2'b10; o.rffun = 3'b010; o.rfreg = 4'b1000 >> dst;
    end else if (ir[15:14] == 2'b01) begin
      o.asel = {1'b0, ir[4:3]}; o.bsel = {1'b0, ir[1:0]};
      o.alufun = {1'b1, op}; o.wf = ir[9];
      o.rffun = 3'b010; o.rfreg = 4'b1000 >> dst;
    end else if (ir[15:14] == 2'b00) begin
      taken = (op == 0) || (op == 1 && fl[3]) || (op == 2 && !fl[3]) || (op == 3 && fl[2]);
      if (taken) begin
        o.mb = 2'b11; o.arfreg = 3'b100; o.arffun = 2'b10;
      end
    end else if (ir[15:14] == 2'b10) begin
      o.dsel = 2'b01; o.cs = 1'b0;
      if (ir[13]) begin
        o.asel = {1'b0, ir[4:3]}; o.alufun = 5'b10000; o.wr = 1'b1;
      end else begin
        o.dre = 1'b1; o.drfun = 2'b01;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
    n_cmp++;
    if (InstrCount !== m_count) begin
      n_bad++;
      $display("FAIL %s t=%0t: InstrCount got %h expected %h", name, $time, InstrCount, m_count);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock); Reset = 1'b0; #1;
    chk("reset_idle0", idle_out());
    @(negedge Clock); #1;
    chk("reset_idle1", idle_out());
    m_count = '0;
    @(negedge Clock); Reset = 1'b1; #1;
    chk("init_outputs", init_out());
    chk_cnt("count_after_reset");
  endtask

  // Runs one instruction from T0; for halting ones, also checks several HALT cycles.
  task automatic do_instr(input logic [15:0] ir, input logic [3:0] fl, output out_t t2);
    int n = instr_len(ir);
    t2 = '0;
    for (int p = 0; p < n; p++) begin
      @(negedge Clock); IROut = ir; Flags = fl; #1;
      chk($sformatf("ir%h_p%0d", ir, p), exp_out(p, ir, fl));
      chk_cnt("count_in_instr");
      if (p == 2) t2 = act;
    end
    if (is_halt(ir)) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge Clock); IROut = $urandom; Flags = $urandom; #1;
        begin
          out_t h = idle_out();
          h.halted = 1'b1;
          chk("halt_idle", h);
        end
        chk_cnt("count_in_halt");
      end
    end else begin
`ifdef SEQ_INSTR_COUNT_EN
      m_count = m_count + 16'd1;
`endif
    end
  endtask

  vec_t vecs[$];
  out_t t2;
  logic [15:0] r_ir;

  initial begin
    vecs.push_back('{16'h5281, 4'b0000, 3'b000, 5'b10100, 4'b0010, 2'b00});
    vecs.push_back('{16'h0440, 4'b1000, 3'b100, 5'b00000, 4'b0000, 2'b11});
    vecs.push_back('{16'h0440, 4'b0000, 3'b000, 5'b00000, 4'b0000, 2'b00});
    vecs.push_back('{16'h0840, 4'b0000, 3'b100, 5'b00000, 4'b0000, 2'b11});
    vecs.push_back('{16'h0C00, 4'b0100, 3'b100, 5'b00000, 4'b0000, 2'b11});
    vecs.push_back('{16'h0C00, 4'b1011, 3'b000, 5'b00000, 4'b0000, 2'b00});
    vecs.push_back('{16'h0000, 4'b0000, 3'b100, 5'b00000, 4'b0000, 2'b11});
    vecs.push_back('{16'h1000, 4'b1111, 3'b000, 5'b00000, 4'b0000, 2'b00});
    vecs.push_back('{16'h8080, 4'b0000, 3'b000, 5'b00000, 4'b0000, 2'b00});
    vecs.push_back('{16'hA018, 4'b0000, 3'b000, 5'b10000, 4'b0000, 2'b00});
    vecs.push_back('{16'h7DC7, 4'b0000, 3'b000, 5'b11111, 4'b0001, 2'b00});

    do_reset();

    foreach (vecs[i]) begin
      do_instr(vecs[i].ir, vecs[i].fl, t2);
      n_cmp++;
      if (t2.arfreg !== vecs[i].e_arfreg || t2.alufun !== vecs[i].e_alufun ||
          t2.rfreg !== vecs[i].e_rfreg || t2.mb !== vecs[i].e_mb) begin
        n_bad++;
        $display("FAIL vec%0d_t2 ir=%h: got arf=%b alu=%b rf=%b mb=%b expected arf=%b alu=%b rf=%b mb=%b",
                 i, vecs[i].ir, t2.arfreg, t2.alufun, t2.rfreg, t2.mb,
                 vecs[i].e_arfreg, vecs[i].e_alufun, vecs[i].e_rfreg, vecs[i].e_mb);
      end
    end

    // Count scenario: 3 ALU + 1 LD after a fresh reset.
    do_reset();
    do_instr(16'h5281, 4'b0000, t2);
    do_instr(16'h4A5B, 4'b0000, t2);
    do_instr(16'h7000, 4'b0000, t2);
    do_instr(16'h80C0, 4'b0000, t2);
    @(negedge Clock); #1;
    chk_cnt("count_3alu_1ld");

    do_reset();
    for (int i = 0; i < 250; i++) begin
      do begin
        r_ir = $urandom;
      end while (is_halt(r_ir));
      do_instr(r_ir, 4'($urandom), t2);
    end

    do_instr(16'h3C00, 4'b0000, t2);
    do_reset();
    do_instr(16'hC000, 4'b0000, t2);
    do_reset();

    // Reset asserted during T1 abandons the instruction with no write.
    do_instr(16'h5281, 4'b0000, t2);
    @(negedge Clock); IROut = 16'h8080; #1;
    chk("mid_t0", exp_out(0, 16'h8080, 4'b0000));
    @(negedge Clock); Reset = 1'b0; #1;
    chk("mid_t1_reset_idle", idle_out());
    m_count = '0;
    @(negedge Clock); Reset = 1'b1; #1;
    chk("mid_t1_init", init_out());
    chk_cnt("mid_t1_count");
    do_instr(16'h8080, 4'b0000, t2);
    @(negedge Clock); #1;
    chk("recover_t0", exp_out(0, 16'h0000, 4'b0000));
    chk_cnt("recover_count");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
